uart_core: RTL and testbench

Parametrised full-duplex UART for the FPGA designs: one transmitter and one 16x-oversampling receiver, both running on the system clock. A clock-enable tick replaces any divided or derived clock. Data moves to and from user logic over valid/ready handshakes. Frame width, parity and stop bits are set by parameters, and received bytes carry framing, parity and overrun status. It sits between the board `rxd`/`txd` pins and user logic; an echo top-level ties `rx_*` directly to `tx_*`.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_core.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM encodings and the baud divider calculation for the UART.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        TxIdle,
        TxStart,
        TxData,
        TxParity,
        TxStop
    } tx_state_e;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxParity,
        RxStop
    } rx_state_e;

    // Rounded division: clocks per oversample tick.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned den;
        den = baud * oversample;
        return (clk_freq + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module uart_baud_tick #(
    parameter int unsigned DIV = 10,
    parameter int unsigned W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [W-1:0] cnt_q;
    logic         wrap;

    assign wrap = (cnt_q == W'(DIV - 1));
    assign tick = wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: tick-driven transmitter and 16x-oversampling receiver with
// valid/ready user interfaces and framing/parity/overrun status.
module uart_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic                 txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 tx_busy
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    logic tick;

    uart_baud_tick #(
        .DIV (DIV),
        .W   (CW)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // ---------------------------------------------------------------- TX
    tx_state_e            tx_state_q, tx_state_d;
    logic [OW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_BITS-1:0] tx_buf_q, tx_buf_d;
    logic                 tx_pend_q, tx_pend_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_bit_end;

    assign tx_ready   = (tx_state_q == TxIdle) && !tx_pend_q;
    assign tx_busy    = !tx_ready;
    assign txd        = txd_q;
    assign tx_bit_end = (tx_cnt_q == OW'(OVERSAMPLE - 1));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_pend_d  = tx_pend_q;
        tx_par_d   = tx_par_q;
        txd_d      = 1'b1;

        if (tx_valid && tx_ready) begin
            tx_pend_d = 1'b1;
            tx_buf_d  = tx_data;
        end

        if (tick) begin
            if (tx_state_q != TxIdle) begin
                tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
            end
            unique case (tx_state_q)
                TxIdle: begin
                    if (tx_pend_q) begin
                        tx_state_d = TxStart;
                        tx_cnt_d   = '0;
                        tx_shift_d = tx_buf_q;
                        tx_par_d   = (PARITY == PAR_ODD) ? ~^tx_buf_q : ^tx_buf_q;
                        tx_pend_d  = 1'b0;
                    end
                end
                TxStart: begin
                    if (tx_bit_end) begin
                        tx_state_d = TxData;
                        tx_bit_d   = '0;
                    end
                end
                TxData: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                            tx_bit_d   = '0;
                            tx_state_d = (PARITY == PAR_NONE) ? TxStop : TxParity;
                        end else begin
                            tx_bit_d   = tx_bit_q + 1'b1;
                            tx_shift_d = tx_shift_q >> 1;
                        end
                    end
                end
                TxParity: begin
                    if (tx_bit_end) begin
                        tx_state_d = TxStop;
                        tx_bit_d   = '0;
                    end
                end
                TxStop: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == BW'(STOP_BITS - 1)) begin
                            tx_state_d = TxIdle;
                        end else begin
                            tx_bit_d = tx_bit_q + 1'b1;
                        end
                    end
                end
                default: tx_state_d = TxIdle;
            endcase
        end

        // Line level follows the next state so txd is a clean flop output.
        unique case (tx_state_d)
            TxStart:  txd_d = 1'b0;
            TxData:   txd_d = tx_shift_d[0];
            TxParity: txd_d = tx_par_d;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_pend_q  <= 1'b0;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_pend_q  <= tx_pend_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    // ---------------------------------------------------------------- RX
    rx_state_e            rx_state_q, rx_state_d;
    logic [OW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rxd_meta_q, rxd_sync_q;
    logic                 rx_done;
    logic                 rx_mid, rx_half;

    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_pout_q, rx_pout_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_accept;

    assign rx_mid  = (rx_cnt_q == OW'(OVERSAMPLE - 1));
    assign rx_half = (rx_cnt_q == OW'(OVERSAMPLE / 2 - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_done    = 1'b0;

        if (tick) begin
            unique case (rx_state_q)
                RxIdle: begin
                    if (!rxd_sync_q) begin
                        rx_state_d = RxStart;
                        rx_cnt_d   = '0;
                        rx_perr_d  = 1'b0;
                    end
                end
                RxStart: begin
                    if (rx_half) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rxd_sync_q ? RxIdle : RxData;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (rx_mid) begin
                        rx_cnt_d   = '0;
                        rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == BW'(DATA_BITS - 1)) begin
                            rx_state_d = (PARITY == PAR_NONE) ? RxStop : RxParity;
                        end else begin
                            rx_bit_d = rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
                RxParity: begin
                    if (rx_mid) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RxStop;
                        rx_perr_d  = (PARITY == PAR_ODD) ? ~(rxd_sync_q ^ (^rx_shift_q))
                                                         : (rxd_sync_q ^ (^rx_shift_q));
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    // Only the first stop bit is checked; idle again allows mid-stop resync.
                    if (rx_mid) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RxIdle;
                        rx_done    = 1'b1;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
                default: rx_state_d = RxIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
        end
    end

    // Output register; a handshake in the same cycle as a new frame is not an overrun.
    assign rx_accept = rx_valid_q && rx_ready;

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ferr_d  = rx_ferr_q;
        rx_pout_d  = rx_pout_q;
        rx_ovr_d   = rx_ovr_q;

        if (rx_accept) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
        if (rx_done) begin
            rx_valid_d = 1'b1;
            rx_data_d  = rx_shift_q;
            rx_ferr_d  = !rxd_sync_q;
            rx_pout_d  = rx_perr_q;
            if (rx_valid_q && !rx_accept) begin
                rx_ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_pout_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_pout_q  <= rx_pout_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_parity_err = rx_pout_q;
    assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench: an 8N1 instance (loopback or bench-driven rxd) and an 8E1
// instance driven by the bench, with expected RX bytes queued at stimulus time.
module tb_uart_core;

    localparam int unsigned CF  = 1_600_000;
    localparam int unsigned BD  = 10_000;
    localparam int          BIT = 160;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 8N1 instance
    logic       a_rxd, a_txd, a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
    logic       a_ferr, a_perr, a_ovr, a_busy, loop_a, drv_a;
    logic [7:0] a_tx_data, a_rx_data;
    assign a_rxd = loop_a ? a_txd : drv_a;

    uart_core #(
        .CLK_FREQ (CF), .BAUD (BD), .OVERSAMPLE (16), .DATA_BITS (8), .PARITY (0), .STOP_BITS (1)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .rxd (a_rxd), .txd (a_txd),
        .tx_data (a_tx_data), .tx_valid (a_tx_valid), .tx_ready (a_tx_ready),
        .rx_data (a_rx_data), .rx_valid (a_rx_valid), .rx_ready (a_rx_ready),
        .rx_frame_err (a_ferr), .rx_parity_err (a_perr), .rx_overrun (a_ovr), .tx_busy (a_busy)
    );

    // 8E1 instance, receive side only exercised
    logic       drv_p, p_txd, p_tx_ready, p_rx_valid, p_ferr, p_perr, p_ovr, p_busy;
    logic       p_tx_valid, p_rx_ready;
    logic [7:0] p_tx_data, p_rx_data;

    uart_core #(
        .CLK_FREQ (CF), .BAUD (BD), .OVERSAMPLE (16), .DATA_BITS (8), .PARITY (2), .STOP_BITS (1)
    ) u_dut_p (
        .clk (clk), .rst_n (rst_n), .rxd (drv_p), .txd (p_txd),
        .tx_data (p_tx_data), .tx_valid (p_tx_valid), .tx_ready (p_tx_ready),
        .rx_data (p_rx_data), .rx_valid (p_rx_valid), .rx_ready (p_rx_ready),
        .rx_frame_err (p_ferr), .rx_parity_err (p_perr), .rx_overrun (p_ovr), .tx_busy (p_busy)
    );

    exp_t exp_a[$];
    exp_t exp_p[$];
    exp_t e_a, e_p;
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_t r;
        r.data = d;
        r.perr = p;
        r.ferr = f;
        r.ovr  = o;
        return r;
    endfunction

    // Handshake monitors: compare each delivered byte against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && a_rx_valid && a_rx_ready) begin
            if (exp_a.size() == 0) begin
                check_eq("a_unexpected_rx", {24'd0, a_rx_data}, 32'hFFFF_FFFF);
            end else begin
                e_a = exp_a.pop_front();
                check_eq("a_rx_data", {24'd0, a_rx_data}, {24'd0, e_a.data});
                check_eq("a_rx_parity_err", {31'd0, a_perr}, {31'd0, e_a.perr});
                check_eq("a_rx_frame_err", {31'd0, a_ferr}, {31'd0, e_a.ferr});
                check_eq("a_rx_overrun", {31'd0, a_ovr}, {31'd0, e_a.ovr});
            end
        end
        if (rst_n && p_rx_valid && p_rx_ready) begin
            if (exp_p.size() == 0) begin
                check_eq("p_unexpected_rx", {24'd0, p_rx_data}, 32'hFFFF_FFFF);
            end else begin
                e_p = exp_p.pop_front();
                check_eq("p_rx_data", {24'd0, p_rx_data}, {24'd0, e_p.data});
                check_eq("p_rx_parity_err", {31'd0, p_perr}, {31'd0, e_p.perr});
                check_eq("p_rx_frame_err", {31'd0, p_ferr}, {31'd0, e_p.ferr});
            end
        end
    end

    // Serialise frame[0] first onto the selected bench-driven line, then idle high.
    task automatic drive_frame(input int sel, input logic [15:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (sel == 0) drv_a = frame[i];
            else          drv_p = frame[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        drv_a = 1'b1;
        drv_p = 1'b1;
    endtask

    task automatic tx_send(input logic [7:0] d);
        for (int n = 0; n < 5000 && !a_tx_ready; n++) begin
            @(posedge clk);
            #1;
        end
        check_eq("tx_ready_wait", {31'd0, a_tx_ready}, 32'd1);
        a_tx_data  = d;
        a_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        a_tx_valid = 1'b0;
    endtask

    task automatic drain(input int sel, input string tag);
        for (int i = 0; i < 4000; i++) begin
            if ((sel == 0 ? exp_a.size() : exp_p.size()) == 0) break;
            @(posedge clk);
            #1;
        end
        check_eq(tag, sel == 0 ? exp_a.size() : exp_p.size(), 32'd0);
    endtask

    task automatic wait_txd_fall(output int n);
        n = 0;
        while (n < 40 && a_txd) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int         n;
        int         m;
        logic [9:0] pat;

        rst_n      = 1'b0;
        a_tx_valid = 1'b0;
        a_tx_data  = '0;
        a_rx_ready = 1'b1;
        loop_a     = 1'b1;
        drv_a      = 1'b1;
        drv_p      = 1'b1;
        p_tx_valid = 1'b0;
        p_tx_data  = '0;
        p_rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check_eq("rst_txd", {31'd0, a_txd}, 32'd1);
        check_eq("rst_tx_ready", {31'd0, a_tx_ready}, 32'd1);
        check_eq("rst_tx_busy", {31'd0, a_busy}, 32'd0);
        check_eq("rst_rx_valid", {31'd0, a_rx_valid}, 32'd0);
        check_eq("rst_rx_data", {24'd0, a_rx_data}, 32'd0);
        check_eq("rst_flags", {29'd0, a_ferr, a_perr, a_ovr}, 32'd0);

        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 loopback of 0xA5 with bit-level timing
        exp_a.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
        tx_send(8'hA5);
        check_eq("tx_ready_drop", {31'd0, a_tx_ready}, 32'd0);
        check_eq("tx_busy_set", {31'd0, a_busy}, 32'd1);
        wait_txd_fall(n);
        check_eq("txd_fall_latency_ok", {31'd0, (n >= 1 && n <= 11)}, 32'd1);
        pat = {1'b1, 8'hA5, 1'b0};
        repeat (BIT / 2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("txd_bit%0d", i), {31'd0, a_txd}, {31'd0, pat[i]});
            if (i < 9) begin
                repeat (BIT) @(posedge clk);
                #1;
            end
        end
        m = BIT / 2 + 9 * BIT;
        while (!a_tx_ready && m < 2000) begin
            @(posedge clk);
            #1;
            m++;
        end
        check_eq("tx_frame_len", m, 32'd1600);
        check_eq("tx_busy_clear", {31'd0, a_busy}, 32'd0);
        drain(0, "drain_loopback");

        // Even parity: 0x03 needs parity 0
        exp_p.push_back(mk(8'h03, 1'b1, 1'b0, 1'b0));
        drive_frame(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
        drain(1, "drain_par_bad");
        exp_p.push_back(mk(8'h03, 1'b0, 1'b0, 1'b0));
        drive_frame(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
        drain(1, "drain_par_good");
        exp_p.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
        drive_frame(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        drain(1, "drain_par_odd_weight");

        // Start-bit glitch rejection, then a clean frame
        loop_a = 1'b0;
        drv_a  = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        drv_a = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check_eq("glitch_no_valid", {31'd0, a_rx_valid}, 32'd0);
        exp_a.push_back(mk(8'h5A, 1'b0, 1'b0, 1'b0));
        drive_frame(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
        drain(0, "drain_after_glitch");

        // Frame error: stop bit driven low
        exp_a.push_back(mk(8'hFF, 1'b0, 1'b1, 1'b0));
        drive_frame(0, {6'b0, 1'b0, 8'hFF, 1'b0}, 10);
        drain(0, "drain_frame_err");
        repeat (400) @(posedge clk);
        #1;

        // Overrun: two frames with the consumer stalled
        loop_a     = 1'b1;
        a_rx_ready = 1'b0;
        tx_send(8'h11);
        exp_a.push_back(mk(8'h22, 1'b0, 1'b0, 1'b1));
        tx_send(8'h22);
        for (int i = 0; i < 2000 && !a_tx_ready; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (20) @(posedge clk);
        #1;
        check_eq("ovr_set", {31'd0, a_ovr}, 32'd1);
        check_eq("ovr_data_held", {24'd0, a_rx_data}, 32'h22);
        a_rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ovr_cleared", {31'd0, a_ovr}, 32'd0);
        check_eq("ovr_valid_cleared", {31'd0, a_rx_valid}, 32'd0);
        drain(0, "drain_overrun");

        // Reset in the middle of data bit 3
        tx_send(8'h3C);
        wait_txd_fall(n);
        repeat (BIT / 2 + 4 * BIT) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_txd", {31'd0, a_txd}, 32'd1);
        check_eq("rstmid_tx_ready", {31'd0, a_tx_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (1200) @(posedge clk);
        #1;
        check_eq("rstmid_no_valid", {31'd0, a_rx_valid}, 32'd0);
        exp_a.push_back(mk(8'hC3, 1'b0, 1'b0, 1'b0));
        tx_send(8'hC3);
        drain(0, "drain_after_reset");

        repeat (50) @(posedge clk);
        #1;
        check_eq("final_queue_a", exp_a.size(), 32'd0);
        check_eq("final_queue_p", exp_p.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
